fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the synchronous instruction memory.
- Generates the fetch PC and drives the memory address.
- Pairs each returned instruction with its PC and presents a valid/PC/instruction triple to decode.
- Handles decode back-pressure (stall) and control-flow redirects (branch/jump), absorbing the memory's 1-cycle read latency with a one-entry hold register.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BYTE_ADDR, 0, 0: imem_addr = {2'b00, fetch_pc[31:2]} (word index); 1: imem_addr = fetch_pc (byte address).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  32  address to instruction memory; equals f(fetch_pc) combinationally.
- imem_inst  in  32  memory read data; valid 1 cycle after the address edge.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  if_pc/if_inst are valid.
- if_pc  out  32  PC of presented instruction.
- if_inst  out  32  presented instruction.

Behaviour:
- Registers:
  - fetch_pc: address currently on imem_addr.
  - resp_pc: PC of the data on imem_inst.
  - state: EMPTY / LIVE / HELD.
  - hold_inst: 32-bit hold register.
- Outputs:
  - if_valid = (state != EMPTY).
  - if_pc = resp_pc.
  - if_inst = hold_inst when state is HELD, otherwise imem_inst.
- Reset (rst=1 at edge): fetch_pc <= RESET_PC; state <= EMPTY; resp_pc <= RESET_PC; hold_inst <= 0. While reset, if_valid=0. First valid output (PC RESET_PC) appears 1 cycle after the first edge with rst=0.
- Reset mid-operation discards everything, including held data.
- Priority at each edge: rst > redirect_valid > stall > advance.
- Redirect: fetch_pc <= redirect_pc; state <= EMPTY (in-flight and held instructions squashed). The following cycle shows a 1-cycle bubble (if_valid=0); the target instruction is valid the cycle after. Redirect overrides a simultaneous stall.
- Stall (no redirect): fetch_pc and resp_pc frozen. LIVE -> HELD with hold_inst <= imem_inst. HELD stays HELD. EMPTY stays EMPTY. Because fetch_pc is frozen, the memory keeps re-reading fetch_pc, so imem_inst = mem[fetch_pc] on release.
- Advance (no stall, no redirect): resp_pc <= fetch_pc; fetch_pc <= fetch_pc + 4, wrapping modulo 2^32; state <= LIVE. This covers leaving HELD and leaving EMPTY.
- Throughput: 1 instruction/cycle without stall. No instruction is lost or duplicated across any stall pattern.
- if_pc/if_inst are don't-care when if_valid=0. The bench must not check them.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Extra output port if_misaligned (1 bit).
  - A redirect with redirect_pc[1:0] != 0 loads fetch_pc and sets a sticky fault flag.
  - Next cycle: if_valid=1, if_pc=redirect_pc, if_inst=32'h0000_0013 (NOP), if_misaligned=1.
  - fetch_pc is frozen and no memory data is presented until the next redirect or reset clears the flag.
  - Stall holds the fault presentation.
- Undefined: no port; redirect_pc[1:0] is forced to 2'b00 on load.

Decomposition:
- Package hotate_fetch_pkg:
  - typedef enum fetch_state_t {EMPTY, LIVE, HELD}.
  - Localparam PC_STEP = 32'd4.
  - Localparam INST_NOP = 32'h0000_0013.
- Sub-module fetch_hold_reg: 32-bit capture register with load/clear, used for hold_inst.
- PC and state logic stay in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, memory holds word n = n, BYTE_ADDR=0 -> if_valid rises 1 cycle after release; if_pc 0,4,8,C; if_inst 0,1,2,3; imem_addr 0,1,2,3,4.
- Stall 3 cycles while presenting PC 8 -> if_pc=8, if_inst=2 held all 3 cycles; after release, PC C (inst 3) next cycle with no gap or duplicate.
- redirect_valid=1, redirect_pc=0x40 while PC 4 is presented -> next cycle if_valid=0; following cycle if_pc=0x40, if_inst=0x10, then 0x44.
- Redirect and stall in the same cycle -> redirect wins; stall is ignored for that edge; target appears after 1 bubble.
- fetch_pc=0xFFFF_FFFC, advance -> next fetch_pc=0x0000_0000. Also rst asserted during HELD -> if_valid=0 next cycle; restart at RESET_PC.
- FETCH_MISALIGN_CHECK_EN defined, redirect_pc=0x42 -> next cycle if_valid=1, if_misaligned=1, if_inst=0x13, persists until redirect to 0x40 clears it.

Source files
------------

// File: rtl/hotate_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package hotate_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LIVE  = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_reg.sv
// Capture register with synchronous clear and load; clear has priority.
module fetch_hold_reg
    import hotate_fetch_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, response pairing and stall hold buffering.
// Optional FETCH_MISALIGN_CHECK_EN adds if_misaligned and a sticky misaligned-redirect fault.
module fetch_unit
    import hotate_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter bit              BYTE_ADDR = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            if_misaligned
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] hold_inst;
    logic            hold_load;
    logic            fault_q, fault_d;

    fetch_hold_reg #(.W(XLEN)) u_hold (
        .clk   (clk),
        .clear (rst),
        .load  (hold_load),
        .d     (imem_inst),
        .q     (hold_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            fault_q    <= fault_d;
        end
    end

    // Priority: redirect > (fault freeze) > stall > advance.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        fault_d    = fault_q;
        hold_load  = 1'b0;
        if (redirect_valid) begin
            state_d = EMPTY;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_pc_d = redirect_pc;
            fault_d    = (redirect_pc[1:0] != 2'b00);
            if (redirect_pc[1:0] != 2'b00) begin
                resp_pc_d = redirect_pc;
            end
        end else if (fault_q) begin
            fetch_pc_d = fetch_pc_q;
`else
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            fault_d    = 1'b0;
`endif
        end else if (stall) begin
            if (state_q == LIVE) begin
                state_d   = HELD;
                hold_load = 1'b1;
            end
        end else begin
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = LIVE;
        end
    end

    assign imem_addr = BYTE_ADDR ? fetch_pc_q : {2'b00, fetch_pc_q[XLEN-1:2]};
    assign if_valid  = (state_q != EMPTY) || fault_q;
    assign if_pc     = resp_pc_q;
    assign if_inst   = fault_q             ? INST_NOP  :
                       (state_q == HELD)   ? hold_inst : imem_inst;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign if_misaligned = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a stream model.
module tb_fetch_unit;
    import hotate_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = 32'd0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what decode should see, and the next PC the stream will deliver.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_next  = 32'd0;
    logic        m_fault = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BYTE_ADDR(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .if_misaligned  (if_misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: word n holds n.
    always @(posedge clk) imem_inst <= imem_addr;

    function automatic logic [31:0] m_inst();
        return m_fault ? INST_NOP : (m_pc >> 2);
    endfunction

    // Drive one cycle of inputs, take the edge, advance the model, settle.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic st);
        rst = r; redirect_valid = rv; redirect_pc = rpc; stall = st;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_next = 32'd0; m_fault = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0; m_fault = 1'b0; m_next = rpc & ~32'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_next = rpc;
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1; m_valid = 1'b1; m_pc = rpc;
            end
`endif
        end else if (!m_fault && !st) begin
            m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            n_checks++;
            if (if_valid !== 1'b0 || imem_addr !== 32'd0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: valid=%b addr=%h, need 0/00000000", i, if_valid, imem_addr);
            end
        end
    endtask

    task automatic test_stream();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_inst !== 32'(i) || imem_addr !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL stream cyc%0d: valid=%b pc=%h inst=%h addr=%h, need 1/%h/%h/%h",
                         i, if_valid, if_pc, if_inst, imem_addr, 32'(4 * i), 32'(i), 32'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'h2) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: valid=%b pc=%h inst=%h, need 1/00000008/00000002", i, if_valid, if_pc, if_inst);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(12 + 4 * i) || if_inst !== 32'(3 + i)) begin
                n_fail++;
                $display("FAIL stall_release cyc%0d: valid=%b pc=%h inst=%h, need 1/%h/%h",
                         i, if_valid, if_pc, if_inst, 32'(12 + 4 * i), 32'(3 + i));
            end
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_bubble: valid=%b, need 0", if_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(32'h40 + 4 * i) || if_inst !== 32'(32'h10 + i)) begin
                n_fail++;
                $display("FAIL redirect_target cyc%0d: valid=%b pc=%h inst=%h, need 1/%h/%h",
                         i, if_valid, if_pc, if_inst, 32'(32'h40 + 4 * i), 32'(32'h10 + i));
            end
        end
    endtask

    task automatic test_redirect_stall();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h80, 1'b1);
        n_checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL redir_stall_bubble: valid=%b addr=%h, need 0/00000020", if_valid, imem_addr);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_inst !== 32'h20) begin
            n_fail++;
            $display("FAIL redir_stall_target: valid=%b pc=%h inst=%h, need 1/00000080/00000020", if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_wrap_and_reset_held();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h3FFF_FFFF || imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_last: valid=%b pc=%h inst=%h addr=%h, need 1/fffffffc/3fffffff/00000000",
                     if_valid, if_pc, if_inst, imem_addr);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: valid=%b pc=%h inst=%h, need 1/00000000/00000000", if_valid, if_pc, if_inst);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b, need 0", if_valid);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_restart: valid=%b pc=%h inst=%h, need 1/00000000/00000000", if_valid, if_pc, if_inst);
        end
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        step(1'b0, 1'b1, 32'h42, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_misaligned !== 1'b1 || if_pc !== 32'h42 || if_inst !== 32'h13) begin
                n_fail++;
                $display("FAIL misalign cyc%0d: valid=%b mis=%b pc=%h inst=%h, need 1/1/00000042/00000013",
                         i, if_valid, if_misaligned, if_pc, if_inst);
            end
            step(1'b0, 1'b0, 32'd0, (i == 0));
        end
        step(1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (if_valid !== 1'b1 || if_misaligned !== 1'b0 || if_pc !== 32'h40 || if_inst !== 32'h10) begin
            n_fail++;
            $display("FAIL misalign_clear: valid=%b mis=%b pc=%h inst=%h, need 1/0/00000040/00000010",
                     if_valid, if_misaligned, if_pc, if_inst);
        end
    endtask
`endif

    task automatic test_random();
        logic        r, rv, st;
        logic [31:0] rpc;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            rv  = ($urandom_range(0, 99) < 10);
            st  = ($urandom_range(0, 99) < 40);
            rpc = $urandom_range(0, 4095);
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(r, rv, rpc, st);
            n_checks++;
            if (if_valid !== m_valid || imem_addr !== (m_next >> 2)
`ifdef FETCH_MISALIGN_CHECK_EN
                || if_misaligned !== m_fault
`endif
                || (m_valid && (if_pc !== m_pc || if_inst !== m_inst()))) begin
                n_fail++;
                $display("FAIL random cyc%0d: valid=%b pc=%h inst=%h addr=%h, need %b/%h/%h/%h",
                         i, if_valid, if_pc, if_inst, imem_addr, m_valid, m_pc, m_inst(), m_next >> 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap_and_reset_held();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
